// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline: holds one instruction, waits for its data-SRAM
// response, and passes payload plus raw read data to WB. It also drops orphaned responses after a flush.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_maddr,
    input  logic [7:0]  ex_mem_op,
    input  logic        ex_res_from_mem,
    input  logic        ex_gr_we,
    input  logic        ex_mem_req,
    input  logic        ex_has_exception,
    input  logic        ex_ertn,
    input  logic [4:0]  ex_dest,
    input  logic [5:0]  ex_ecode,
    input  logic [8:0]  ex_esubcode,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_result,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_maddr,
    output logic [7:0]  wb_mem_op,
    output logic [4:0]  wb_dest,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        wb_res_from_mem,
    output logic        wb_gr_we,
    output logic        wb_has_exception,
    output logic        wb_ertn,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_data,
    output logic        fwd_load_pending,
    output logic        mem_except
);

    logic        valid;
    logic        pending;
    logic        captured;
    logic        discard;
    logic [31:0] rdata_buf;
    logic        ready_go;
    logic        accept;
    logic        resp_live;
    logic        leave;

    // Handshake: a transfer happens on a rising edge where both valid and ready are high;
    // a valid holder keeps its payload stable until that edge, and ready may depend on valid.
    assign resp_live = data_sram_data_ok && !discard;
    assign ready_go  = valid && (!pending || resp_live);
    assign out_valid = ready_go;
    assign leave     = ready_go && out_ready;
    assign in_ready  = rst && (!valid || leave);
    assign accept    = in_valid && in_ready && !flush;

    assign wb_rdata         = captured ? rdata_buf : data_sram_rdata;
    assign fwd_valid        = valid && wb_gr_we && !wb_has_exception;
    assign fwd_dest         = wb_dest;
    assign fwd_data         = wb_result;
    assign fwd_load_pending = valid && wb_res_from_mem;
    assign mem_except       = valid && (wb_has_exception || wb_ertn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid            <= 1'b0;
            pending          <= 1'b0;
            captured         <= 1'b0;
            discard          <= 1'b0;
            rdata_buf        <= 32'h0;
            wb_pc            <= 32'h0;
            wb_result        <= 32'h0;
            wb_maddr         <= 32'h0;
            wb_mem_op        <= 8'h0;
            wb_dest          <= 5'h0;
            wb_ecode         <= 6'h0;
            wb_esubcode      <= 9'h0;
            wb_res_from_mem  <= 1'b0;
            wb_gr_we         <= 1'b0;
            wb_has_exception <= 1'b0;
            wb_ertn          <= 1'b0;
        end else if (flush) begin
            // A still-outstanding request from either killed instruction becomes an orphan.
            valid    <= 1'b0;
            captured <= 1'b0;
            pending  <= 1'b0;
            discard  <= (discard && !data_sram_data_ok)
                        || (valid && pending && !resp_live)
                        || (in_valid && ex_mem_req);
        end else begin
            if (data_sram_data_ok && discard) begin
                discard <= 1'b0;
            end else if (data_sram_data_ok && pending) begin
                rdata_buf <= data_sram_rdata;
                captured  <= 1'b1;
                pending   <= 1'b0;
            end
            if (accept) begin
                valid            <= 1'b1;
                pending          <= ex_mem_req;
                captured         <= 1'b0;
                wb_pc            <= ex_pc;
                wb_result        <= ex_result;
                wb_maddr         <= ex_maddr;
                wb_mem_op        <= ex_mem_op;
                wb_dest          <= ex_dest;
                wb_ecode         <= ex_ecode;
                wb_esubcode      <= ex_esubcode;
                wb_res_from_mem  <= ex_res_from_mem;
                wb_gr_we         <= ex_gr_we;
                wb_has_exception <= ex_has_exception;
                wb_ertn          <= ex_ertn;
            end else if (leave) begin
                valid    <= 1'b0;
                captured <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load latency, WB stall buffering,
// flush with orphaned and satisfied responses, exceptions and asynchronous reset.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [31:0] ex_maddr;
    logic [7:0]  ex_mem_op;
    logic        ex_res_from_mem;
    logic        ex_gr_we;
    logic        ex_mem_req;
    logic        ex_has_exception;
    logic        ex_ertn;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
    logic [31:0] wb_rdata;
    logic [31:0] wb_maddr;
    logic [7:0]  wb_mem_op;
    logic [4:0]  wb_dest;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_res_from_mem;
    logic        wb_gr_we;
    logic        wb_has_exception;
    logic        wb_ertn;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_load_pending;
    logic        mem_except;

    int n_checks;
    int n_errors;

    mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_maddr(ex_maddr),
        .ex_mem_op(ex_mem_op), .ex_res_from_mem(ex_res_from_mem),
        .ex_gr_we(ex_gr_we), .ex_mem_req(ex_mem_req),
        .ex_has_exception(ex_has_exception), .ex_ertn(ex_ertn),
        .ex_dest(ex_dest), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_pc(wb_pc), .wb_result(wb_result), .wb_rdata(wb_rdata), .wb_maddr(wb_maddr),
        .wb_mem_op(wb_mem_op), .wb_dest(wb_dest), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_res_from_mem(wb_res_from_mem),
        .wb_gr_we(wb_gr_we), .wb_has_exception(wb_has_exception), .wb_ertn(wb_ertn),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .fwd_load_pending(fwd_load_pending), .mem_except(mem_except)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid         = 1'b0;
        ex_pc            = 32'h0;
        ex_result        = 32'h0;
        ex_maddr         = 32'h0;
        ex_mem_op        = 8'h0;
        ex_res_from_mem  = 1'b0;
        ex_gr_we         = 1'b0;
        ex_mem_req       = 1'b0;
        ex_has_exception = 1'b0;
        ex_ertn          = 1'b0;
        ex_dest          = 5'h0;
        ex_ecode         = 6'h0;
        ex_esubcode      = 9'h0;
    endtask

    // Present a LW on the EX side; the caller ticks to accept it.
    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] dest);
        idle_inputs();
        in_valid        = 1'b1;
        ex_pc           = pc;
        ex_result       = 32'h0000_1000;
        ex_mem_op       = 8'h04;
        ex_res_from_mem = 1'b1;
        ex_gr_we        = 1'b1;
        ex_mem_req      = 1'b1;
        ex_dest         = dest;
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        flush             = 1'b0;
        out_ready         = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        idle_inputs();
        #2 rst = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fwd_valid", fwd_valid, 0);
        chk("reset_mem_except", mem_except, 0);
        chk("reset_wb_result", wb_result, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // ALU op
        idle_inputs();
        in_valid  = 1'b1;
        ex_pc     = 32'h1c00_0000;
        ex_result = 32'h5;
        ex_gr_we  = 1'b1;
        ex_dest   = 5'd3;
        #1;
        chk("alu_in_ready", in_ready, 1);
        tick();
        idle_inputs();
        chk("alu_out_valid", out_valid, 1);
        chk("alu_wb_pc", wb_pc, 32'h1c00_0000);
        chk("alu_wb_result", wb_result, 32'h5);
        chk("alu_fwd_valid", fwd_valid, 1);
        chk("alu_fwd_dest", fwd_dest, 3);
        chk("alu_fwd_data", fwd_data, 32'h5);
        chk("alu_load_pending", fwd_load_pending, 0);
        tick();
        chk("alu_drained", out_valid, 0);

        // LW with data_ok three cycles after acceptance
        drive_lw(32'h1c00_0004, 5'd4);
        tick();
        idle_inputs();
        chk("lw_wait1_out_valid", out_valid, 0);
        chk("lw_wait1_pending", fwd_load_pending, 1);
        chk("lw_wait1_in_ready", in_ready, 0);
        tick();
        chk("lw_wait2_out_valid", out_valid, 0);
        chk("lw_wait2_pending", fwd_load_pending, 1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hdead_beef;
        #1;
        chk("lw_ok_out_valid", out_valid, 1);
        chk("lw_ok_rdata", wb_rdata, 32'hdead_beef);
        chk("lw_ok_pending", fwd_load_pending, 1);
        chk("lw_ok_in_ready", in_ready, 1);
        chk("lw_ok_mem_op", wb_mem_op, 8'h04);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("lw_drained", out_valid, 0);

        // LW whose response arrives while WB stalls
        drive_lw(32'h1c00_0008, 5'd5);
        tick();
        idle_inputs();
        out_ready         = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hdead_beef;
        #1;
        chk("stall_ok_out_valid", out_valid, 1);
        chk("stall_ok_in_ready", in_ready, 0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("stall1_out_valid", out_valid, 1);
        chk("stall1_rdata", wb_rdata, 32'hdead_beef);
        chk("stall1_in_ready", in_ready, 0);
        tick();
        chk("stall2_rdata", wb_rdata, 32'hdead_beef);
        chk("stall2_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", in_ready, 1);
        tick();
        chk("stall_drained", out_valid, 0);

        // Flush while LW pending: its late response must be dropped
        drive_lw(32'h1c00_000c, 5'd6);
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_load_pending", fwd_load_pending, 0);
        drive_lw(32'h1c00_0010, 5'd7);
        #1;
        chk("flush_refill_in_ready", in_ready, 1);
        tick();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1;
        #1;
        chk("orphan_out_valid", out_valid, 0);
        tick();
        data_sram_rdata = 32'h2;
        #1;
        chk("live_out_valid", out_valid, 1);
        chk("live_rdata", wb_rdata, 32'h2);
        chk("live_pc", wb_pc, 32'h1c00_0010);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("live_drained", out_valid, 0);

        // Flush coinciding with data_ok: no orphan left behind
        drive_lw(32'h1c00_0014, 5'd8);
        tick();
        idle_inputs();
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h33;
        tick();
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("flushok_out_valid", out_valid, 0);
        drive_lw(32'h1c00_0018, 5'd9);
        tick();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h44;
        #1;
        chk("flushok_next_out_valid", out_valid, 1);
        chk("flushok_next_rdata", wb_rdata, 32'h44);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;

        // Exception, then back-to-back ertn
        idle_inputs();
        in_valid         = 1'b1;
        ex_pc            = 32'h1c00_001c;
        ex_maddr         = 32'h0000_bad0;
        ex_gr_we         = 1'b1;
        ex_has_exception = 1'b1;
        ex_ecode         = 6'h09;
        ex_esubcode      = 9'h001;
        ex_dest          = 5'd10;
        tick();
        idle_inputs();
        in_valid = 1'b1;
        ex_pc    = 32'h1c00_0020;
        ex_ertn  = 1'b1;
        #1;
        chk("exc_mem_except", mem_except, 1);
        chk("exc_out_valid", out_valid, 1);
        chk("exc_has_exception", wb_has_exception, 1);
        chk("exc_ecode", wb_ecode, 6'h09);
        chk("exc_esubcode", wb_esubcode, 9'h001);
        chk("exc_maddr", wb_maddr, 32'h0000_bad0);
        chk("exc_fwd_valid", fwd_valid, 0);
        chk("exc_b2b_in_ready", in_ready, 1);
        tick();
        idle_inputs();
        chk("ertn_mem_except", mem_except, 1);
        chk("ertn_wb_ertn", wb_ertn, 1);
        chk("ertn_has_exception", wb_has_exception, 0);
        chk("ertn_pc", wb_pc, 32'h1c00_0020);
        tick();
        chk("ertn_drained_except", mem_except, 0);

        // Asynchronous reset while an orphan is outstanding clears the orphan
        drive_lw(32'h1c00_0024, 5'd11);
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_wb_pc", wb_pc, 0);
        tick();
        rst = 1'b1;
        drive_lw(32'h1c00_0028, 5'd12);
        tick();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55;
        #1;
        chk("arst_next_out_valid", out_valid, 1);
        chk("arst_next_rdata", wb_rdata, 32'h55);
        tick();
        data_sram_data_ok = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
